rom_sequencer: RTL and testbench

Program sequencer for the 9-bit micro: holds the program counter and addresses the combinational instruction ROM. It latches each fetched word and resolves nop and jump internally. All other instructions are issued to the register/ALU datapath over a valid/ready handshake. It sits between the ROM (`i_Address`/`o_Instruction`) and the datapath, and is the only master of the ROM address.

---
 rtl/rom_sequencer.sv | 140 ++++++++++++++
 tb/tb_rom_sequencer.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sequencer.sv
// rom_sequencer: PC owner and ROM fetch/issue engine for the 9-bit micro.
// Build option ROM_SEQ_SINGLE_STEP_EN adds i_Step to gate FETCH -> ISSUE.
module rom_sequencer #(
    parameter logic [7:0] END_ADDR = 8'd13,
    parameter logic [8:0] NOP_WORD = 9'h1FF
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Run,
    output logic [7:0] o_Address,
    input  logic [8:0] i_Instruction,
    output logic [8:0] o_Instr,
    output logic       o_ExecValid,
    input  logic       i_ExecReady,
    input  logic       i_ZeroFlag,
    output logic [7:0] o_PC,
    output logic       o_Busy,
    output logic       o_Halted
`ifdef ROM_SEQ_SINGLE_STEP_EN
    ,
    input  logic       i_Step
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t     state;
    logic [7:0] pc;
    logic [7:0] pc_inc;
    logic [7:0] jump_target;
    logic [7:0] next_pc;
    logic       fetch_go;
    logic       fetch_exec;
    logic       is_nop;
    logic       is_jump;
    logic       jump_taken;
    logic       retire;

`ifdef ROM_SEQ_SINGLE_STEP_EN
    assign fetch_go = i_Step;
`else
    assign fetch_go = 1'b1;
`endif

    assign o_Address   = pc;
    assign o_PC        = pc;
    assign pc_inc      = pc + 8'd1;
    assign jump_target = {5'b0, o_Instr[5:3]};

    assign is_nop  = (o_Instr == NOP_WORD);
    assign is_jump = !is_nop && (o_Instr[8:6] == 3'b110);

    // Only words that reach the datapath raise valid once latched.
    assign fetch_exec = (i_Instruction != NOP_WORD) &&
                        (i_Instruction[8:6] != 3'b110);

    // Jump condition from the low three bits and the live zero flag.
    always_comb begin
        jump_taken = 1'b0;
        unique case (o_Instr[2:0])
            3'b000:  jump_taken = 1'b1;
            3'b001:  jump_taken = i_ZeroFlag;
            3'b011:  jump_taken = !i_ZeroFlag;
            default: jump_taken = 1'b0;
        endcase
    end

    // Retire decision and successor PC for the word held in ISSUE.
    always_comb begin
        retire  = 1'b0;
        next_pc = pc_inc;
        unique case (1'b1)
            is_nop: begin
                retire = 1'b1;
            end
            is_jump: begin
                retire = 1'b1;
                if (jump_taken) begin
                    next_pc = jump_target;
                end
            end
            default: begin
                retire = o_ExecValid & i_ExecReady;
            end
        endcase
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            pc          <= 8'd0;
            o_Instr     <= 9'h1FF;
            o_ExecValid <= 1'b0;
            o_Busy      <= 1'b0;
            o_Halted    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_Run) begin
                        state  <= S_FETCH;
                        o_Busy <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (fetch_go) begin
                        o_Instr     <= i_Instruction;
                        o_ExecValid <= fetch_exec;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (retire) begin
                        pc          <= next_pc;
                        o_ExecValid <= 1'b0;
                        if (pc == END_ADDR) begin
                            state    <= S_HALT;
                            o_Busy   <= 1'b0;
                            o_Halted <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_sequencer.sv
// tb_rom_sequencer: scoreboard bench for rom_sequencer.
// A program-level model predicts the issued stream; a monitor compares.
module tb_rom_sequencer;

    typedef struct {
        logic [7:0] a;
        logic [8:0] i;
    } ex_t;

    localparam logic [8:0] NOP = 9'h1FF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, run, rdy, ovr_en, ovr_zf, zf;
    logic [7:0] addr, pc;
    logic [8:0] rom_q, instr;
    logic       valid, busy, halted;
`ifdef ROM_SEQ_SINGLE_STEP_EN
    logic       step;
`endif

    logic       rst_w, run_w, rdy_w, zf_w;
    logic [7:0] addr_w, pc_w;
    logic [8:0] rom_q_w, instr_w;
    logic       valid_w, busy_w, halted_w;

    logic [8:0] rom   [0:255];
    logic [8:0] rom_w [0:255];
    bit         zmap  [0:3][0:255];
    logic [1:0] pass, pass_w;
    logic [7:0] last_pc, last_pc_w;

    ex_t q[$], q_w[$], mq[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_hs  = 0;
    bit  seen_wrap = 0;

    assign rom_q   = rom[addr];
    assign rom_q_w = rom_w[addr_w];
    assign zf      = ovr_en ? ovr_zf : zmap[pass][pc];
    assign zf_w    = (pass_w != 2'd0);

    rom_sequencer u_dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Run         (run),
        .o_Address     (addr),
        .i_Instruction (rom_q),
        .o_Instr       (instr),
        .o_ExecValid   (valid),
        .i_ExecReady   (rdy),
        .i_ZeroFlag    (zf),
        .o_PC          (pc),
        .o_Busy        (busy),
        .o_Halted      (halted)
`ifdef ROM_SEQ_SINGLE_STEP_EN
        ,
        .i_Step        (step)
`endif
    );

    rom_sequencer #(.END_ADDR(8'd3)) u_wrap (
        .i_Clk         (clk),
        .i_Reset       (rst_w),
        .i_Run         (run_w),
        .o_Address     (addr_w),
        .i_Instruction (rom_q_w),
        .o_Instr       (instr_w),
        .o_ExecValid   (valid_w),
        .i_ExecReady   (rdy_w),
        .i_ZeroFlag    (zf_w),
        .o_PC          (pc_w),
        .o_Busy        (busy_w),
        .o_Halted      (halted_w)
`ifdef ROM_SEQ_SINGLE_STEP_EN
        ,
        .i_Step        (1'b1)
`endif
    );

    // Count backward PC moves; the zero-flag map is indexed by it.
    always @(posedge clk) begin
        if (rst) begin
            pass    <= 2'd0;
            last_pc <= 8'd0;
        end else begin
            if (pc < last_pc && pass != 2'd3) pass <= pass + 2'd1;
            last_pc <= pc;
        end
    end

    // Same bookkeeping for the wrap instance.
    always @(posedge clk) begin
        if (rst_w) begin
            pass_w    <= 2'd0;
            last_pc_w <= 8'd0;
        end else begin
            if (pc_w < last_pc_w && pass_w != 2'd3)
                pass_w <= pass_w + 2'd1;
            last_pc_w <= pc_w;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit isjump(input logic [8:0] w);
        return (w != NOP) && (w[8:6] == 3'b110);
    endfunction

    function automatic bit jtaken(input logic [8:0] w, input bit z);
        if (w[2:0] == 3'b000) return 1'b1;
        if (w[2:0] == 3'b001) return z;
        if (w[2:0] == 3'b011) return !z;
        return 1'b0;
    endfunction

    // Walks the program one instruction at a time; issued words go to mq.
    function automatic void predict(input bit w, input logic [7:0] end_a,
                                    output logic [7:0] fin, output bit ok);
        logic [7:0] p, nx;
        logic [8:0] wd;
        int ps;
        bit z;
        ex_t e;
        mq.delete();
        p = 8'd0;
        ps = 0;
        ok = 1'b0;
        fin = 8'd0;
        for (int s = 0; s < 600; s++) begin
            wd = w ? rom_w[p] : rom[p];
            z = w ? (ps != 0) : zmap[ps][p];
            nx = p + 8'd1;
            if (wd != NOP && isjump(wd)) begin
                if (jtaken(wd, z)) nx = {5'd0, wd[5:3]};
            end else if (wd != NOP) begin
                e.a = p;
                e.i = wd;
                mq.push_back(e);
            end
            if (p == end_a) begin
                fin = nx;
                ok = 1'b1;
                return;
            end
            if (nx < p && ps < 3) ps++;
            p = nx;
        end
    endfunction

    function automatic logic [8:0] rnd_data();
        logic [8:0] d;
        d = 9'($urandom);
        if (d[8:6] == 3'b110 || d[8:6] == 3'b111) d[8] = 1'b0;
        return d;
    endfunction

    // Main monitor: scoreboard pops, handshake rules, jump and halt timing.
    initial begin
        logic pv = 0, phs = 0, prst = 1, hnext = 0, pj = 0;
        logic [8:0] pins = 0;
        logic [7:0] paddr = 0, pjexp = 0;
        logic hs;
        ex_t e;
        forever begin
            @(negedge clk);
            hs = 1'b0;
            if (!rst) begin
                if (!prst && pv && !phs) begin
                    chk("hold_valid", valid, 1);
                    chk("hold_instr", instr, pins);
                end
                if (hnext) begin
                    chk("halt_rise", halted, 1);
                    chk("halt_busy", busy, 0);
                end
                if (!prst && pj && addr != paddr)
                    chk("jump_next_addr", addr, pjexp);
                if (valid) begin
                    chk("valid_word", instr, rom[addr]);
                    chk("valid_not_ctl",
                        isjump(rom[addr]) || rom[addr] == NOP, 0);
                end
                hs = valid && rdy;
                if (hs) begin
                    n_hs++;
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_issue: got %0h@%0h expected none",
                                 instr, pc);
                    end else begin
                        e = q.pop_front();
                        chk("issue_addr", pc, e.a);
                        chk("issue_word", instr, e.i);
                    end
                end
            end
            hnext = !rst && hs && (pc == 8'd13);
            pj = !rst && isjump(rom[addr]);
            paddr = addr;
            pjexp = jtaken(rom[addr], zf) ? {5'd0, rom[addr][5:3]}
                                          : addr + 8'd1;
            pv = valid;
            phs = hs;
            pins = instr;
            prst = rst;
        end
    end

    // Wrap-instance monitor.
    initial begin
        logic hnext = 0;
        logic [7:0] ppc = 0;
        ex_t e;
        forever begin
            @(negedge clk);
            if (!rst_w) begin
                if (hnext) chk("w_halt_rise", halted_w, 1);
                if (ppc == 8'd255 && pc_w == 8'd0) seen_wrap = 1'b1;
                if (valid_w && rdy_w) begin
                    if (q_w.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL w_unexpected_issue: got %0h@%0h expected none",
                                 instr_w, pc_w);
                    end else begin
                        e = q_w.pop_front();
                        chk("w_issue_addr", pc_w, e.a);
                        chk("w_issue_word", instr_w, e.i);
                    end
                end
            end
            hnext = !rst_w && valid_w && rdy_w && (pc_w == 8'd3);
            ppc = rst_w ? 8'd0 : pc_w;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic load_directed();
        logic [8:0] dw [0:13];
        dw = '{9'h1FF, 9'h00A, 9'h013, 9'h01C, 9'h025, 9'h02E, 9'h037,
               9'h040, 9'h049, 9'h052, 9'h05B, 9'h1AB, 9'h064, 9'h06D};
        for (int a = 0; a < 256; a++) rom[a] = NOP;
        for (int a = 0; a < 14; a++) rom[a] = dw[a];
        for (int p = 0; p < 4; p++)
            for (int a = 0; a < 256; a++) zmap[p][a] = 1'b0;
        zmap[1][11] = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic kick(input bit chk0);
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        @(negedge clk);
        chk("run_busy", busy, 1);
        chk("run_addr0", addr, 0);
        @(negedge clk);
        if (chk0) chk("first_valid_n2", valid, 1);
    endtask

    task automatic run_to_halt(input int lim);
        int k;
        for (k = 0; k < lim; k++) begin
            @(posedge clk); #1 rdy = ($urandom_range(0, 3) != 0);
            if (halted) break;
        end
        if (k >= lim) begin
            n_cmp++;
            n_bad++;
            $display("FAIL halt_timeout: got busy expected halt");
        end
    endtask

    initial begin
        logic [7:0] fin;
        bit ok;
        int tries, k, h0;
        rst = 1; run = 0; rdy = 0; ovr_en = 1; ovr_zf = 0;
        rst_w = 1; run_w = 0; rdy_w = 0;
`ifdef ROM_SEQ_SINGLE_STEP_EN
        step = 1;
`endif
        load_directed();
        rom_w[0] = 9'h1A3;
        for (int a = 1; a < 256; a++) rom_w[a] = rnd_data();

        // Reset with inputs toggling.
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            run = 1'($urandom); rdy = 1'($urandom); ovr_zf = 1'($urandom);
            @(negedge clk);
            chk("rst_addr", addr, 0);
            chk("rst_pc", pc, 0);
            chk("rst_instr", instr, 9'h1FF);
            chk("rst_valid", valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_halted", halted, 0);
        end
        @(posedge clk); #1;
        rst = 0; run = 0; rdy = 0; ovr_en = 0;

        // Directed program: nop, backpressure, jump both ways, halt.
        predict(0, 8'd13, fin, ok);
        q = mq;
        kick(0);
        @(negedge clk);
        chk("fetch1_valid", valid, 0);
        chk("fetch1_addr", addr, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", valid, 1);
            chk("bp_instr", instr, 9'h00A);
            chk("bp_pc", pc, 1);
        end
        @(posedge clk); #1 rdy = 1'b1;
        @(negedge clk);
        chk("bp_pc_ready", pc, 1);
        @(negedge clk);
        chk("bp_pc_after", pc, 2);
        run_to_halt(300);
        @(negedge clk);
        chk("dir_halted", halted, 1);
        chk("dir_final_pc", pc, fin);
        chk("dir_drained", q.size(), 0);
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        repeat (3) @(negedge clk);
        chk("halt_sticky", halted, 1);
        chk("halt_run_busy", busy, 0);
        chk("halt_run_pc", pc, fin);

        // Reset while a handshake is pending.
        do_reset();
        rdy = 1'b0;
        q.delete();
        predict(0, 8'd13, fin, ok);
        q = mq;
        kick(0);
        k = 0;
        while (!valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("midrst_saw_valid", valid, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midrst_valid", valid, 0);
        chk("midrst_pc", pc, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_instr", instr, 9'h1FF);

        // Random programs against the model.
        for (int it = 0; it < 8; it++) begin
            tries = 0;
            do begin
                for (int a = 0; a < 14; a++) begin
                    k = $urandom_range(0, 9);
                    if (k < 2) rom[a] = NOP;
                    else if (k < 4)
                        rom[a] = {3'b110, 3'($urandom), 3'($urandom)};
                    else rom[a] = rnd_data();
                    for (int p = 0; p < 4; p++) zmap[p][a] = 1'($urandom);
                end
                if (it == 0) rom[0] = rnd_data();
                predict(0, 8'd13, fin, ok);
                tries++;
            end while (!ok && tries < 100);
            if (!ok) begin
                for (int a = 0; a < 14; a++) rom[a] = rnd_data();
                predict(0, 8'd13, fin, ok);
            end
            do_reset();
            q = mq;
            rdy = 1'($urandom);
            kick(it == 0);
            run_to_halt(400);
            @(negedge clk);
            chk("rnd_halted", halted, 1);
            chk("rnd_final_pc", pc, fin);
            chk("rnd_drained", q.size(), 0);
        end

        // PC wrap 255 -> 0 on the END_ADDR=3 instance.
        @(posedge clk); #1 rst_w = 1'b0;
        predict(1, 8'd3, fin, ok);
        q_w = mq;
        @(posedge clk); #1 run_w = 1'b1;
        @(posedge clk); #1 run_w = 1'b0;
        for (k = 0; k < 3000; k++) begin
            @(posedge clk); #1 rdy_w = ($urandom_range(0, 3) != 0);
            if (halted_w) break;
        end
        @(negedge clk);
        chk("wrap_halted", halted_w, 1);
        chk("wrap_seen", seen_wrap, 1);
        chk("wrap_final_pc", pc_w, fin);
        chk("wrap_drained", q_w.size(), 0);

`ifdef ROM_SEQ_SINGLE_STEP_EN
        // Single step: FETCH holds until each i_Step pulse.
        load_directed();
        rom[0] = 9'h005;
        step = 1'b0;
        rdy = 1'b1;
        do_reset();
        predict(0, 8'd13, fin, ok);
        q = mq;
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("step_hold_busy", busy, 1);
            chk("step_hold_valid", valid, 0);
            chk("step_hold_pc", pc, 0);
        end
        h0 = n_hs;
        repeat (3) begin
            @(posedge clk); #1 step = 1'b1;
            @(posedge clk); #1 step = 1'b0;
            repeat (3) @(posedge clk);
        end
        @(negedge clk);
        chk("step_pc", pc, 3);
        chk("step_issues", n_hs - h0, 3);
`else
        h0 = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
